// File: rtl/div32_seq_pkg.sv
// Shared types for the sequential divider.
// FSM encoding and mode constants.
package div32_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_SIGNED   = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;

endpackage

// File: rtl/div32_seq_if.sv
// Operand/result handshake bundle.
// master drives operands and out_ready.
interface div32_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dz;
  logic         ovf;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, quo, rem, dz, ovf
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, quo, rem, dz, ovf
  );
endinterface

// File: rtl/div32_seq_step.sv
// One restoring division step.
// Shifts {R,Q} left and conditionally subtracts D.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_nx,
  output logic [W-1:0] q_nx
);

  logic [W:0]   s;
  logic [W+1:0] t;
  logic         ge;

  // trial subtract; the extra top bit is the borrow
  always_comb begin
    s    = {r, q[W-1]};
    t    = {1'b0, s} - {2'b00, d};
    ge   = ~t[W+1];
    r_nx = W'(ge ? t : {1'b0, s});
    q_nx = {q[W-2:0], ge};
  end

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider, signed/unsigned.
// One quotient bit per cycle, valid/ready both sides.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input logic       clk,
  input logic       rst_n,
  div32_seq_if.slave bus
);

  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   r, q, d, a_q;
  logic [W-1:0]   r_nx, q_nx;
  logic           neg_q, neg_r;
  logic           sp_dz, sp_ovf;
  logic [W-1:0]   quo_q, rem_q;
  logic           dz_q, ovf_q;

  logic           acc, sgn;
  logic           a_neg, b_neg;
  logic           is_dz, is_ovf;
  logic [W-1:0]   a_abs, b_abs;

  assign acc    = bus.in_valid && (state == IDLE);
  assign sgn    = (bus.mode == MODE_SIGNED);
  assign a_neg  = sgn & bus.a[W-1];
  assign b_neg  = sgn & bus.b[W-1];
  assign a_abs  = a_neg ? -bus.a : bus.a;
  assign b_abs  = b_neg ? -bus.b : bus.b;
  assign is_dz  = (bus.b == '0);
  assign is_ovf = sgn && (bus.a == MIN) && (bus.b == ONES);

  div_step #(.W(W)) u_step (
    .r    (r),
    .q    (q),
    .d    (d),
    .r_nx (r_nx),
    .q_nx (q_nx)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state; special cases skip the iteration
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc)
              state_nx = (is_dz || is_ovf) ? FIX : CALC;
      CALC: if (cnt == CW'(W-1))
              state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (bus.out_ready)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      a_q    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      sp_dz  <= 1'b0;
      sp_ovf <= 1'b0;
    end else if (acc) begin
      cnt    <= '0;
      r      <= '0;
      q      <= a_abs;
      d      <= b_abs;
      a_q    <= bus.a;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      sp_dz  <= is_dz;
      sp_ovf <= ~is_dz & is_ovf;
    end else if (state == CALC) begin
      cnt    <= cnt + 1'b1;
      r      <= r_nx;
      q      <= q_nx;
    end
  end

  // result registers, written only in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == FIX) begin
      unique case (1'b1)
        sp_dz: begin
          quo_q <= ONES;
          rem_q <= a_q;
          dz_q  <= 1'b1;
          ovf_q <= 1'b0;
        end
        sp_ovf: begin
          quo_q <= MIN;
          rem_q <= '0;
          dz_q  <= 1'b0;
          ovf_q <= 1'b1;
        end
        default: begin
          quo_q <= neg_q ? -q : q;
          rem_q <= neg_r ? -r : r;
          dz_q  <= 1'b0;
          ovf_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quo = quo_q;
  assign bus.rem = rem_q;
  assign bus.dz  = dz_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq.
// Directed, stall, reset and LFSR-random ops.
module tb_div32_seq;
  import div32_seq_pkg::*;

  typedef struct packed {
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic        m;
    logic [31:0] a;
    logic [31:0] b;
    res_t        e;
    logic [5:0]  lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div32_seq_if #(.W(32)) bus ();

  div32_seq #(.W(32), .CW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  res_t        sb[$];
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] lfa = 32'h0000_0001;
  logic [31:0] lfb = 32'hDEAD_BEEF;

  function automatic logic [31:0] lfsr(
    input logic [31:0] s, input logic [31:0] mk);
    return s[0] ? ((s >> 1) ^ mk) : (s >> 1);
  endfunction

  function automatic res_t model(
    input logic m, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    r.dz  = 1'b0;
    r.ovf = 1'b0;
    if (y == 32'd0) begin
      r.quo = 32'hFFFF_FFFF;
      r.rem = x;
      r.dz  = 1'b1;
    end else if (m == MODE_SIGNED && x == 32'h8000_0000 &&
                 y == 32'hFFFF_FFFF) begin
      r.quo = 32'h8000_0000;
      r.rem = 32'd0;
      r.ovf = 1'b1;
    end else if (m == MODE_SIGNED) begin
      r.quo = 32'($signed(x) / $signed(y));
      r.rem = 32'($signed(x) % $signed(y));
    end else begin
      r.quo = x / y;
      r.rem = x % y;
    end
    return r;
  endfunction

  function automatic res_t got();
    res_t r;
    r.quo = bus.quo;
    r.rem = bus.rem;
    r.dz  = bus.dz;
    r.ovf = bus.ovf;
    return r;
  endfunction

  task automatic issue(input logic m, input logic [31:0] x,
                       input logic [31:0] y, input bit push,
                       input res_t e, output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    bus.mode = m;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = bus.in_ready;
    @(posedge clk);
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit rnd, output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic retire(input int stall);
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (got() !== '0) begin
      errors++;
      $display("FAIL rst_out got %h exp 0", got());
    end
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_hs got %b exp 10",
               {bus.in_ready, bus.out_valid});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL idle_hs got %b exp 10",
               {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_directed();
    vec_t tv[10];
    bit   ok;
    int   n;
    res_t e;
    tv[0] = {1'b0, 32'd100, 32'd7,
             32'd14, 32'd2, 2'b00, 6'd33};
    tv[1] = {1'b1, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFD, 32'hFFFFFFFF, 2'b00, 6'd33};
    tv[2] = {1'b1, 32'd7, 32'hFFFFFFFE,
             32'hFFFFFFFD, 32'd1, 2'b00, 6'd33};
    tv[3] = {1'b0, 32'hFFFFFFFF, 32'h10,
             32'h0FFFFFFF, 32'hF, 2'b00, 6'd33};
    tv[4] = {1'b1, 32'hFFFFFFFF, 32'h10,
             32'd0, 32'hFFFFFFFF, 2'b00, 6'd33};
    tv[5] = {1'b0, 32'h1234, 32'd0,
             32'hFFFFFFFF, 32'h1234, 2'b10, 6'd1};
    tv[6] = {1'b1, 32'h1234, 32'd0,
             32'hFFFFFFFF, 32'h1234, 2'b10, 6'd1};
    tv[7] = {1'b1, 32'h80000000, 32'hFFFFFFFF,
             32'h80000000, 32'd0, 2'b01, 6'd1};
    tv[8] = {1'b0, 32'h80000000, 32'hFFFFFFFF,
             32'd0, 32'h80000000, 2'b00, 6'd33};
    tv[9] = {1'b1, 32'h80000000, 32'd1,
             32'h80000000, 32'd0, 2'b00, 6'd33};
    for (int i = 0; i < 10; i++) begin
      issue(tv[i].m, tv[i].a, tv[i].b, 1'b1, tv[i].e, ok);
      vectors++;
      if (!ok) begin
        errors++;
        $display("FAIL dir%0d_accept got 0 exp 1", i);
      end
      wait_out(1'b0, n);
      vectors++;
      if (n != int'(tv[i].lat)) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d exp %0d",
                 i, n, tv[i].lat);
      end
      e = sb.pop_front();
      vectors++;
      if (got() !== e) begin
        errors++;
        $display("FAIL dir%0d_result got %h exp %h", i, got(), e);
      end
      retire(0);
    end
  endtask

  task automatic test_stall();
    bit   ok;
    int   n;
    res_t e;
    e.quo = 32'd333;
    e.rem = 32'd1;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    issue(1'b0, 32'd1000, 32'd3, 1'b1, e, ok);
    wait_out(1'b0, n);
    bus.mode = 1'b0;
    bus.a = 32'd5;
    bus.b = 32'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 ||
          got() !== sb[0]) begin
        errors++;
        $display("FAIL stall%0d got v%b r%b %h exp v1 r0 %h",
                 i, bus.out_valid, bus.in_ready, got(), sb[0]);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    retire(0);
    e = sb.pop_front();
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_release got %b exp 10",
               {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    bit   seen;
    int   n;
    res_t e;
    e = '0;
    issue(1'b0, 32'd12345, 32'd11, 1'b0, e, ok);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_hs got %b exp 10",
               {bus.in_ready, bus.out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_noout got 1 exp 0");
    end
    e.quo = 32'd1122;
    e.rem = 32'd3;
    issue(1'b0, 32'd12345, 32'd11, 1'b1, e, ok);
    wait_out(1'b0, n);
    vectors++;
    if (n != 33) begin
      errors++;
      $display("FAIL midrst_lat got %0d exp 33", n);
    end
    e = sb.pop_front();
    vectors++;
    if (got() !== e) begin
      errors++;
      $display("FAIL midrst_result got %h exp %h", got(), e);
    end
    retire(0);
  endtask

  task automatic test_random();
    bit          ok;
    int          n;
    int          sel;
    logic        m;
    logic [31:0] x, y, ar, ab;
    res_t        e;
    for (int i = 0; i < 1200; i++) begin
      lfa = lfsr(lfa, 32'h8020_0003);
      lfb = lfsr(lfb, 32'h8000_0063);
      m = 1'(i & 1);
      x = lfa;
      y = lfb;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'd0;
      if (sel == 1) y = 32'hFFFF_FFFF;
      if (sel == 1 && (i & 2) != 0) x = 32'h8000_0000;
      if (sel == 2) y = y & 32'hFF;
      if (sel == 3) y = y >> $urandom_range(1, 31);
      e = model(m, x, y);
      issue(m, x, y, 1'b1, e, ok);
      wait_out(1'b1, n);
      vectors++;
      if (n != ((e.dz || e.ovf) ? 1 : 33)) begin
        errors++;
        $display("FAIL rnd%0d_latency got %0d", i, n);
      end
      e = sb.pop_front();
      vectors++;
      if (got() !== e) begin
        errors++;
        $display("FAIL rnd%0d_result m%b a %h b %h got %h exp %h",
                 i, m, x, y, got(), e);
      end
      vectors++;
      if (32'(bus.quo * y + bus.rem) !== x) begin
        errors++;
        $display("FAIL rnd%0d_identity got %h exp %h",
                 i, 32'(bus.quo * y + bus.rem), x);
      end
      if (!e.dz && !e.ovf) begin
        ar = (m && bus.rem[31]) ? -bus.rem : bus.rem;
        ab = (m && y[31]) ? -y : y;
        vectors++;
        if (!(ar < ab)) begin
          errors++;
          $display("FAIL rnd%0d_remmag got %h exp below %h",
                   i, ar, ab);
        end
        if (m) begin
          vectors++;
          if (bus.rem != 32'd0 && bus.rem[31] !== x[31]) begin
            errors++;
            $display("FAIL rnd%0d_remsign got %b exp %b",
                     i, bus.rem[31], x[31]);
          end
        end
      end
      retire($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
